lsu_mem_sequencer: RTL and testbench

//  Load/store sequencer between the RV32I execute stage and a single-port data memory.

---
 rtl/lsu_mem_sequencer_if.sv | 44 ++++
 rtl/lsu_mem_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_lsu_mem_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_sequencer_if.sv
// Signal bundle between the execute stage, the load/store sequencer and the data memory.
// The slave modport is the sequencer's view; master is the surrounding environment's view.
interface lsu_mem_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_is_store;
    logic [2:0]              req_funct3;
    logic [DATA_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [4:0]              req_rd;

    logic                    mem_req;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH/8-1:0] mem_be;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_gnt;
    logic                    mem_rvalid;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    logic                    resp_valid;
    logic [4:0]              resp_rd;
    logic [DATA_WIDTH-1:0]   resp_data;
    logic                    resp_err;
    logic                    busy;

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output resp_valid, resp_rd, resp_data, resp_err, busy
    );

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  resp_valid, resp_rd, resp_data, resp_err, busy
    );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// RV32I load/store sequencer: one request at a time over a req/gnt/rvalid memory port,
// with store lane replication, load extension and misalign/illegal/timeout error reporting.
module lsu_mem_sequencer #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    lsu_mem_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StReq, StWaitR, StResp} state_e;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]            mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [4:0]            rd_q, rd_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  err_q, err_d;
    logic [15:0]           cnt_q, cnt_d;

    logic [1:0]            req_off;
    logic                  funct3_illegal;
    logic                  addr_misaligned;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;
    logic [DATA_WIDTH-1:0] rdata_shift;
    logic [DATA_WIDTH-1:0] load_ext;

    assign req_off = bus.req_addr[1:0];

    // Request decode: legality, alignment and store lane placement.
    always_comb begin
        if (bus.req_is_store) begin
            funct3_illegal = (bus.req_funct3 >= 3'b011);
        end else begin
            funct3_illegal = (bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
        end

        case (bus.req_funct3[1:0])
            2'b01:   addr_misaligned = req_off[0];
            2'b10:   addr_misaligned = |req_off;
            default: addr_misaligned = 1'b0;
        endcase

        st_be    = 4'b1111;
        st_wdata = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << req_off;
                st_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << req_off;
                st_wdata = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Word loads are always aligned, so the shifted word doubles as the LW result.
    assign rdata_shift = bus.mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            3'b001:  load_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            3'b100:  load_ext = {24'd0, rdata_shift[7:0]};
            3'b101:  load_ext = {16'd0, rdata_shift[15:0]};
            default: load_ext = rdata_shift;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        data_d      = data_q;
        err_d       = err_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    rd_d     = bus.req_is_store ? 5'd0 : bus.req_rd;
                    funct3_d = bus.req_funct3;
                    off_d    = req_off;
                    data_d   = '0;
                    if (funct3_illegal || addr_misaligned) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        err_d       = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_is_store;
                        mem_addr_d  = {bus.req_addr[DATA_WIDTH-1:2], 2'b00};
                        mem_be_d    = bus.req_is_store ? st_be : 4'b1111;
                        mem_wdata_d = bus.req_is_store ? st_wdata : '0;
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = mem_we_q ? StResp : StWaitR;
                end
            end
            StWaitR: begin
                // Data beats the timeout when both land in the same cycle.
                if (bus.mem_rvalid) begin
                    data_d  = load_ext;
                    state_d = StResp;
                end else if (cnt_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            off_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            data_q      <= data_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.req_ready  = (state_q == StIdle) && !rst;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rd    = (state_q == StResp) ? rd_q : 5'd0;
    assign bus.resp_data  = (state_q == StResp) ? data_q : '0;
    assign bus.resp_err   = (state_q == StResp) && err_q;
    assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer: drivers push expected responses into a scoreboard,
// a negedge monitor pops and compares them whenever resp_valid is seen.
module tb_lsu_mem_sequencer;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t exp_q[$];

    lsu_mem_sequencer_if bus ();

    lsu_mem_sequencer #(
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL resp_unexpected: got resp_valid=1 rd=%0d data=%h expected no response (cycle %0d)",
                         bus.resp_rd, bus.resp_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_rd", {27'd0, bus.resp_rd}, {27'd0, e.rd});
                check("resp_data", bus.resp_data, e.data);
                check("resp_err", {31'd0, bus.resp_err}, {31'd0, e.err});
                check("resp_cycle", cyc, e.cyc);
            end
        end else begin
            check("resp_idle_zero", bus.resp_data | {26'd0, bus.resp_rd, bus.resp_err}, 32'd0);
        end
    end

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, output int t);
        @(negedge clk);
        check("req_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
        bus.req_rd       = rd;
        t = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                            input int gw, input logic [31:0] eaddr, input logic [3:0] ebe,
                            input logic [31:0] ewdata);
        int   t;
        exp_t e;
        issue(1'b1, f3, addr, wd, 5'd17, t);
        e.rd = 5'd0; e.data = 32'd0; e.err = 1'b0; e.cyc = t + 2 + gw;
        exp_q.push_back(e);
        for (int i = 0; i <= gw; i++) begin
            check("st_mem_req", {31'd0, bus.mem_req}, 32'd1);
            check("st_mem_we", {31'd0, bus.mem_we}, 32'd1);
            check("st_mem_addr", bus.mem_addr, eaddr);
            check("st_mem_be", {28'd0, bus.mem_be}, {28'd0, ebe});
            check("st_mem_wdata", bus.mem_wdata, ewdata);
            if (i == gw) bus.mem_gnt = 1'b1;
            @(negedge clk);
        end
        bus.mem_gnt = 1'b0;
        check("st_mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] eaddr,
                           input logic [4:0] rd, input logic [31:0] rdata, input int gw,
                           input int rw, input logic [31:0] edata);
        int   t;
        exp_t e;
        issue(1'b0, f3, addr, 32'hFFFF_FFFF, rd, t);
        e.rd = rd; e.data = edata; e.err = 1'b0; e.cyc = t + 3 + gw + rw;
        exp_q.push_back(e);
        for (int i = 0; i <= gw; i++) begin
            check("ld_mem_req", {31'd0, bus.mem_req}, 32'd1);
            check("ld_mem_we", {31'd0, bus.mem_we}, 32'd0);
            check("ld_mem_addr", bus.mem_addr, eaddr);
            check("ld_mem_be", {28'd0, bus.mem_be}, 32'h0000_000F);
            // rvalid while still requesting must be ignored
            if (i < gw) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hDEAD_BEEF;
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_gnt    = 1'b1;
            end
            @(negedge clk);
        end
        bus.mem_gnt = 1'b0;
        check("ld_mem_req_drop", {31'd0, bus.mem_req}, 32'd0);
        repeat (rw) @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
    endtask

    task automatic do_err(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [4:0] rd, input logic [4:0] erd);
        int   t;
        exp_t e;
        issue(st, f3, addr, 32'h1111_2222, rd, t);
        e.rd = erd; e.data = 32'd0; e.err = 1'b1; e.cyc = t + 1;
        exp_q.push_back(e);
        check("err_no_mem_req", {31'd0, bus.mem_req}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of stimulus expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   t;
        exp_t e;
        n_tests = 0;
        n_fail  = 0;
        rst              = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'b0;
        bus.req_funct3   = 3'd0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        bus.req_rd       = 5'd0;
        bus.mem_gnt      = 1'b0;
        bus.mem_rvalid   = 1'b1;
        bus.mem_rdata    = 32'hA5A5_A5A5;

        // Reset state, with stale rvalid present throughout.
        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_be", {28'd0, bus.mem_be}, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;

        // Stores
        do_store(3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5);
        do_store(3'b001, 32'h0000_1002, 32'h1234_BEEF, 0, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF);
        do_store(3'b010, 32'h0000_1004, 32'hCAFE_F00D, 0, 32'h0000_1004, 4'b1111, 32'hCAFE_F00D);
        do_store(3'b000, 32'h0000_1001, 32'h0000_005A, 5, 32'h0000_1000, 4'b0010, 32'h5A5A_5A5A);

        // Loads
        do_load(3'b000, 32'h0000_2001, 32'h0000_2000, 5'd3, 32'h0000_F000, 0, 0, 32'hFFFF_FFF0);
        do_load(3'b100, 32'h0000_2001, 32'h0000_2000, 5'd4, 32'h0000_F000, 0, 0, 32'h0000_00F0);
        do_load(3'b001, 32'h0000_2002, 32'h0000_2000, 5'd5, 32'h8001_0000, 0, 0, 32'hFFFF_8001);
        do_load(3'b101, 32'h0000_2002, 32'h0000_2000, 5'd6, 32'h8001_0000, 0, 0, 32'h0000_8001);
        do_load(3'b010, 32'h0000_2004, 32'h0000_2004, 5'd7, 32'h1234_5678, 5, 1, 32'h1234_5678);
        // rvalid lands on the last timeout cycle: data must win
        do_load(3'b000, 32'h0000_2003, 32'h0000_2000, 5'd8, 32'h7F00_0000, 0, 3, 32'h0000_007F);

        // Misaligned and illegal-funct3 requests
        do_err(1'b0, 3'b010, 32'h0000_3002, 5'd9,  5'd9);
        do_err(1'b0, 3'b001, 32'h0000_3001, 5'd10, 5'd10);
        do_err(1'b1, 3'b001, 32'h0000_3003, 5'd11, 5'd0);
        do_err(1'b1, 3'b010, 32'h0000_3001, 5'd12, 5'd0);
        do_err(1'b0, 3'b011, 32'h0000_3000, 5'd13, 5'd13);
        do_err(1'b0, 3'b110, 32'h0000_3000, 5'd14, 5'd14);
        do_err(1'b1, 3'b011, 32'h0000_3000, 5'd15, 5'd0);
        do_err(1'b1, 3'b100, 32'h0000_3000, 5'd16, 5'd0);

        // Timeout: grant at t+1, four WAIT_R cycles, error response at t+6
        issue(1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd18, t);
        e.rd = 5'd18; e.data = 32'd0; e.err = 1'b1; e.cyc = t + 6;
        exp_q.push_back(e);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("to_busy", {31'd0, bus.busy}, 32'd1);
        repeat (5) @(negedge clk);

        // Reset while waiting for read data: no response, late rvalid ignored
        issue(1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd19, t);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.req_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_ready", {31'd0, bus.req_ready}, 32'd1);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
        repeat (2) @(negedge clk);
        check("late_rvalid_busy", {31'd0, bus.busy}, 32'd0);

        do_load(3'b010, 32'h0000_5000, 32'h0000_5000, 5'd20, 32'h0BAD_F00D, 1, 2, 32'h0BAD_F00D);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
